// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage MIPS pipeline: instruction-memory sizing,
// the bubble encoding, primary opcode constants used by fetch and decode, the
// fetch-stage state type and an instruction-memory range check.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned IMEM_DEPTH_DEF = 128;
   localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0020;  // add $0,$0,$0

   // Primary opcodes (instruction bits [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // True when the word addressed by byte address a lies inside the memory.
   function automatic logic in_imem(input logic [31:0] a, input int unsigned depth);
      return ({2'b00, a[31:2]} < depth);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the downstream control requests (stall, redirect) and the IF/ID
// pipeline register outputs of the fetch stage.
//   master : fetch stage  - receives stall/redirect, drives fd_* and halted
//   slave  : decode side  - drives stall/redirect, receives fd_* and halted
// Signals:
//   stall        hold PC and IF/ID (load-use hazard)
//   redirect     taken branch / jr resolved downstream
//   redirect_pc  redirect byte address, bits [1:0] ignored
//   fd_ir        fetched instruction
//   fd_pc        byte address of fd_ir
//   fd_pc4       fd_pc + 4
//   fd_valid     fd_ir is a real instruction (not a bubble)
//   halted       PC has left the instruction memory
// -----------------------------------------------------------------------------
interface fetch_unit_if;

   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] fd_ir;
   logic [31:0] fd_pc;
   logic [31:0] fd_pc4;
   logic        fd_valid;
   logic        halted;

   modport master (
      input  stall, redirect, redirect_pc,
      output fd_ir, fd_pc, fd_pc4, fd_valid, halted
   );

   modport slave (
      output stall, redirect, redirect_pc,
      input  fd_ir, fd_pc, fd_pc4, fd_valid, halted
   );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// -----------------------------------------------------------------------------
// next_pc_sel
// Combinational next-state logic of the fetch stage. Priority in RUN is
// redirect > stall > out-of-range > jump > sequential. In HALT the PC is
// frozen and bubbles are issued until a redirect to an in-range address.
// Ports:
//   state_i             current fetch state
//   pc_i, pc4_i         current PC and PC+4
//   instr_i             word fetched at pc_i (only meaningful when in range)
//   pc_in_range_i       pc_i addresses a word inside the memory
//   stall_i             hold request
//   redirect_i          redirect request
//   redirect_pc_i       redirect byte address
//   pc_d_o              next PC
//   state_d_o           next fetch state
//   load_o              load IF/ID from the current fetch
//   flush_o             load a bubble into IF/ID (fd_pc/fd_pc4 untouched)
// -----------------------------------------------------------------------------
module next_pc_sel
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
   input  fetch_state_e state_i,
   input  logic [31:0]  pc_i,
   input  logic [31:0]  pc4_i,
   input  logic [31:0]  instr_i,
   input  logic         pc_in_range_i,
   input  logic         stall_i,
   input  logic         redirect_i,
   input  logic [31:0]  redirect_pc_i,
   output logic [31:0]  pc_d_o,
   output fetch_state_e state_d_o,
   output logic         load_o,
   output logic         flush_o
);

   logic [31:0] redirect_tgt;
   logic [31:0] jump_tgt;
   logic        tgt_in_range;

   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
   // j keeps the top nibble of the delay-slot address (PC+4), not of PC.
   assign jump_tgt     = {pc4_i[31:28], instr_i[25:0], 2'b00};
   assign tgt_in_range = in_imem(redirect_tgt, IMEM_DEPTH);

   always_comb begin
      pc_d_o    = pc_i;
      state_d_o = state_i;
      load_o    = 1'b0;
      flush_o   = 1'b0;
      case (state_i)
         RUN: begin
            if (redirect_i) begin
               pc_d_o  = redirect_tgt;
               flush_o = 1'b1;
            end else if (stall_i) begin
               // everything holds
            end else if (!pc_in_range_i) begin
               flush_o   = 1'b1;
               state_d_o = HALT;
            end else begin
               load_o = 1'b1;
               pc_d_o = (instr_i[31:26] == OP_J) ? jump_tgt : pc4_i;
            end
         end
         HALT: begin
            // Stall is irrelevant here: only bubbles leave this stage.
            flush_o = 1'b1;
            if (redirect_i && tgt_in_range) begin
               pc_d_o    = redirect_tgt;
               state_d_o = RUN;
            end
         end
         default: begin
            state_d_o = RUN;
         end
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, a
// word-addressed instruction memory (preloaded externally, never cleared),
// decodes j early so jumps cost no bubble, honours stall/redirect from
// downstream and drives the IF/ID register consumed by decode.
// Ports:
//   clk   pipeline clock, rising edge
//   rst   asynchronous active-high reset
//   fif   fetch_unit_if.master: stall, redirect, redirect_pc in;
//         fd_ir, fd_pc, fd_pc4, fd_valid, halted out
// -----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  fif
);

   localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic [31:0] instruction [0:IMEM_DEPTH-1];

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc4;
   logic [31:0]  fetch_word;
   logic [AW-1:0] idx;
   logic         pc_in_range;
   logic         load, flush;

   logic [31:0]  fd_ir_q, fd_pc_q, fd_pc4_q;
   logic         fd_valid_q;

   assign pc4         = pc_q + 32'd4;   // wraps modulo 2^32
   assign idx         = pc_q[AW+1:2];
   assign pc_in_range = in_imem(pc_q, IMEM_DEPTH);
   // The array is only read for in-range PCs.
   assign fetch_word  = pc_in_range ? instruction[idx] : NOP_WORD;

   next_pc_sel #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_next_pc_sel (
      .state_i       (state_q),
      .pc_i          (pc_q),
      .pc4_i         (pc4),
      .instr_i       (fetch_word),
      .pc_in_range_i (pc_in_range),
      .stall_i       (fif.stall),
      .redirect_i    (fif.redirect),
      .redirect_pc_i (fif.redirect_pc),
      .pc_d_o        (pc_d),
      .state_d_o     (state_d),
      .load_o        (load),
      .flush_o       (flush)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // IF/ID register: a flush replaces only the instruction and valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fd_ir_q    <= NOP_WORD;
         fd_pc_q    <= 32'd0;
         fd_pc4_q   <= 32'd4;
         fd_valid_q <= 1'b0;
      end else if (flush) begin
         fd_ir_q    <= NOP_WORD;
         fd_valid_q <= 1'b0;
      end else if (load) begin
         fd_ir_q    <= fetch_word;
         fd_pc_q    <= pc_q;
         fd_pc4_q   <= pc4;
         fd_valid_q <= 1'b1;
      end
   end

   assign fif.fd_ir    = fd_ir_q;
   assign fif.fd_pc    = fd_pc_q;
   assign fif.fd_pc4   = fd_pc4_q;
   assign fif.fd_valid = fd_valid_q;
   assign fif.halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench for fetch_unit: sequential fetch, stall,
// redirect with stall, async reset mid-run, zero-bubble jump, jump-to-self,
// end of memory / HALT and recovery through redirect.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0020;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   fetch_unit_if fif ();

   fetch_unit #(
      .IMEM_DEPTH (128),
      .NOP_WORD   (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word i holds addi-opcode filler tagged with its own index.
   task automatic fill_mem();
      for (int i = 0; i < 128; i++) dut.instruction[i] = 32'h2000_0000 | i;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ir"},    fif.fd_ir,    NOP);
      check({tag, "_pc"},    fif.fd_pc,    32'd0);
      check({tag, "_pc4"},   fif.fd_pc4,   32'd4);
      check({tag, "_valid"}, 32'(fif.fd_valid), 32'd0);
      check({tag, "_halt"},  32'(fif.halted),   32'd0);
      check({tag, "_PC"},    dut.pc_q,     32'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      fif.stall = 1'b0;
      fif.redirect = 1'b0;
      fif.redirect_pc = 32'd0;
      fill_mem();
      dut.instruction[0] = 32'h0022_1820;   // add $3,$1,$2

      #3;
      check_reset("rst0");
      #9;
      rst = 1'b0;                           // t = 12

      // Sequential fetch
      tick();
      check("seq1_ir",    fif.fd_ir,  32'h0022_1820);
      check("seq1_pc",    fif.fd_pc,  32'd0);
      check("seq1_pc4",   fif.fd_pc4, 32'd4);
      check("seq1_valid", 32'(fif.fd_valid), 32'd1);
      tick();
      check("seq2_pc",    fif.fd_pc,  32'd4);
      check("seq2_ir",    fif.fd_ir,  32'h2000_0001);
      check("seq2_pc4",   fif.fd_pc4, 32'd8);
      tick();
      check("seq3_pc",    fif.fd_pc,  32'd8);

      // Stall for two edges
      fif.stall = 1'b1;
      tick();
      check("stl1_pc",    fif.fd_pc,  32'd8);
      check("stl1_ir",    fif.fd_ir,  32'h2000_0002);
      tick();
      check("stl2_pc",    fif.fd_pc,  32'd8);
      check("stl2_valid", 32'(fif.fd_valid), 32'd1);
      fif.stall = 1'b0;
      tick();
      check("stl_rel_pc", fif.fd_pc,  32'd12);
      check("stl_rel_ir", fif.fd_ir,  32'h2000_0003);
      tick();
      check("pre_rd_pc",  fif.fd_pc,  32'd16);

      // Redirect together with stall: redirect wins, low bits dropped
      fif.stall = 1'b1;
      fif.redirect = 1'b1;
      fif.redirect_pc = 32'h0000_0053;
      tick();
      check("rd_valid",   32'(fif.fd_valid), 32'd0);
      check("rd_ir",      fif.fd_ir,  NOP);
      check("rd_pc_hold", fif.fd_pc,  32'd16);
      check("rd_PC",      dut.pc_q,   32'h0000_0050);
      fif.stall = 1'b0;
      fif.redirect = 1'b0;
      tick();
      check("rd2_pc",     fif.fd_pc,  32'h0000_0050);
      check("rd2_ir",     fif.fd_ir,  32'h2000_0014);
      check("rd2_valid",  32'(fif.fd_valid), 32'd1);

      // Async reset between edges, then zero-bubble jump
      #3;
      rst = 1'b1;
      #1;
      check_reset("arst");
      dut.instruction[0]  = 32'h0800_000A;  // j 10
      dut.instruction[10] = 32'h0022_2824;  // and $5,$1,$2
      #2;
      rst = 1'b0;
      tick();
      check("j1_ir",      fif.fd_ir,  32'h0800_000A);
      check("j1_pc",      fif.fd_pc,  32'd0);
      tick();
      check("j2_pc",      fif.fd_pc,  32'd40);
      check("j2_ir",      fif.fd_ir,  32'h0022_2824);
      check("j2_valid",   32'(fif.fd_valid), 32'd1);
      check("j2_pc4",     fif.fd_pc4, 32'd44);
      tick();
      check("j3_pc",      fif.fd_pc,  32'd44);

      // Jump to own address loops with valid instructions
      #3;
      rst = 1'b1;
      fill_mem();
      dut.instruction[2] = 32'h0800_0002;   // j 2
      #2;
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("loop1_pc",   fif.fd_pc,  32'd8);
      check("loop1_ir",   fif.fd_ir,  32'h0800_0002);
      tick();
      check("loop2_pc",   fif.fd_pc,  32'd8);
      check("loop2_valid",32'(fif.fd_valid), 32'd1);
      tick();
      check("loop3_pc",   fif.fd_pc,  32'd8);
      check("loop3_PC",   dut.pc_q,   32'd8);

      // Run off the end of memory
      #3;
      rst = 1'b1;
      fill_mem();
      #2;
      rst = 1'b0;
      repeat (128) tick();
      check("end_pc",     fif.fd_pc,  32'd508);
      check("end_PC",     dut.pc_q,   32'd512);
      check("end_halt0",  32'(fif.halted), 32'd0);
      tick();
      check("oor_halt",   32'(fif.halted),   32'd1);
      check("oor_valid",  32'(fif.fd_valid), 32'd0);
      check("oor_ir",     fif.fd_ir,  NOP);
      check("oor_PC",     dut.pc_q,   32'd512);
      check("oor_pc",     fif.fd_pc,  32'd508);
      fif.stall = 1'b1;
      tick();
      check("hlt_stl",    32'(fif.halted), 32'd1);
      check("hlt_stl_PC", dut.pc_q,   32'd512);
      fif.stall = 1'b0;
      fif.redirect = 1'b1;
      fif.redirect_pc = 32'h0000_1000;      // still out of range
      tick();
      check("hlt_oor_rd", 32'(fif.halted), 32'd1);
      check("hlt_oor_PC", dut.pc_q,   32'd512);
      fif.redirect_pc = 32'd0;
      tick();
      check("rec_halt",   32'(fif.halted),   32'd0);
      check("rec_valid",  32'(fif.fd_valid), 32'd0);
      check("rec_PC",     dut.pc_q,   32'd0);
      fif.redirect = 1'b0;
      tick();
      check("rec2_pc",    fif.fd_pc,  32'd0);
      check("rec2_valid", 32'(fif.fd_valid), 32'd1);
      check("rec2_ir",    fif.fd_ir,  32'h2000_0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
